// File: rtl/fsm_seq_pkg.sv
// ============================================================================
// fsm_seq_pkg : shared types and constants for the serial pattern generator
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fsm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [9:0] DEFAULT_PATTERN = 10'b0001111010;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift_reg.sv
// ============================================================================
// piso_shift_reg : parallel-load, MSB-first shift register (LSB fills with 0)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module piso_shift_reg #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_en_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_en_i) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/fsm_seq_generator.sv
// ============================================================================
// fsm_seq_generator : word-to-serial pattern generator with hold and repeat
// Revision          : 1.0
// ============================================================================
`default_nettype none

module fsm_seq_generator
  import fsm_seq_pkg::*;
#(
  parameter int               WIDTH   = 10,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEFAULT_PATTERN)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [WIDTH-1:0]              load_data,
  input  logic                          repeat_en,
  input  logic                          hold,
  output logic                          x,
  output logic                          x_valid,
  output logic [cnt_width(WIDTH)-1:0]   bits_left,
  output logic                          done
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] word_q;

  logic             sr_load;
  logic             sr_shift;
  logic             sr_msb;
  logic [WIDTH-1:0] sr_data;

  // Shift register is reloaded on a fresh handshake or on a repeat from DONE
  assign sr_load  = ((state_q == IDLE) && load_valid) || ((state_q == DONE) && repeat_en);
  assign sr_data  = (state_q == IDLE) ? load_data : word_q;
  assign sr_shift = (state_q == SHIFT) && !hold;

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load_i    (sr_load),
    .data_i    (sr_data),
    .shift_en_i(sr_shift),
    .msb_o     (sr_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= PATTERN;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            word_q  <= load_data;
            cnt_q   <= CW'(WIDTH);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (!hold) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (repeat_en) begin
            cnt_q   <= CW'(WIDTH);
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs depend on registered state only; the line is forced low outside SHIFT
  assign load_ready = (state_q == IDLE);
  assign x_valid    = (state_q == SHIFT);
  assign x          = (state_q == SHIFT) && sr_msb;
  assign bits_left  = (state_q == SHIFT) ? cnt_q : '0;
  assign done       = (state_q == DONE);

endmodule

`default_nettype wire
